// File: rtl/boolean_sweep_pkg.sv
// boolean_sweep_pkg: shared state encoding and constants for the boolean sweep sequencer
package boolean_sweep_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;
    localparam logic [7:0] EXPECT_DEFAULT = 8'h15;
    localparam int CNT_W = 4;
endpackage

// File: rtl/boolean_sweep_ctrl_settle_timer.sv
// sweep_settle_timer: settle-window counter, expired flags the last cycle of the window
module sweep_settle_timer
    import boolean_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= load ? '0 : en ? cnt + 1'b1 : cnt;
    assign expired = cnt == CNT_W'(SETTLE_CYCLES - 1);
endmodule

// File: rtl/boolean_sweep_ctrl.sv
// boolean_sweep_ctrl: exhaustive truth-table sweep of a combinational block against a golden table
// Optional BOOLEAN_SWEEP_STOP_ON_FAIL_EN: halt on the first mismatch and report fail_idx.
module boolean_sweep_ctrl
    import boolean_sweep_pkg::*;
#(
    parameter int N_IN = 3,
    parameter logic [2**N_IN-1:0] EXPECT = EXPECT_DEFAULT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 dut_d,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
    output logic [N_IN-1:0]      fail_idx,
`endif
    output logic [2**N_IN-1:0]   captured
);
    state_t state, nxt;
    logic accept, mismatch, last, stop_hit, finish, expired, load;
    assign accept   = (state == IDLE || state == DONE) && start;
    assign mismatch = dut_d != EXPECT[vec];
    assign last     = vec == '1;
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
    assign stop_hit = mismatch;
`else
    assign stop_hit = 1'b0;
`endif
    assign finish = last || stop_hit;
    assign load   = accept || (state == SAMPLE && !finish);

    sweep_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .en(state == DRIVE),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = start ? DRIVE : state;
            DRIVE:      nxt = expired ? SAMPLE : DRIVE;
            SAMPLE:     nxt = finish ? DONE : DRIVE;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state == DRIVE || state == SAMPLE;
        done = state == DONE;
    end

    // Results are cleared on acceptance and only touched in SAMPLE, so dut_d glitches in DRIVE never land.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vec       <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            captured  <= '0;
        end else if (accept) begin
            vec       <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            captured  <= '0;
        end else if (state == SAMPLE) begin
            captured[vec] <= dut_d;
            if (mismatch && err_count != '1) err_count <= err_count + 1'b1;
            if (finish) pass <= !mismatch && err_count == '0;
            else vec <= vec + 1'b1;
        end

`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fail_idx <= '0;
        else if (accept) fail_idx <= '0;
        else if (state == SAMPLE && mismatch) fail_idx <= vec;
`endif
endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// tb_boolean_sweep_ctrl: directed self-checking bench for boolean_sweep_ctrl
module tb_boolean_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n, start, dut_d;
    logic [2:0] vec;
    logic busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] captured;
    int mode;
    int checks = 0;
    int errors = 0;
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
    logic [2:0] fail_idx;
`endif

    always #5 clk = ~clk;

    // mode 0: correct ~((a&b)|c); 1: stuck at one; 2: inverted function
    assign dut_d = mode == 0 ? ~((vec[2] & vec[1]) | vec[0]) :
                   mode == 1 ? 1'b1 : ((vec[2] & vec[1]) | vec[0]);

    boolean_sweep_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dut_d(dut_d),
        .vec(vec),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
        .fail_idx(fail_idx),
`endif
        .captured(captured)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
        check("accept_vec", 32'(vec), 32'd0);
        check("accept_err", 32'(err_count), 32'd0);
        check("accept_cap", 32'(captured), 32'd0);
    endtask

    task automatic sweep(input int len, input int p1, input int p2, input bit chk_vec);
        for (int n = 1; n <= len; n++) begin
            @(posedge clk);
            #1 start = 1'b0;
            if (chk_vec && n % 3 == 1) check("vec_order", 32'(vec), 32'((n - 1) / 3));
            if (n == len - 1) check("done_early", 32'(done), 32'd0);
            if (n == len) check("done_rise", 32'(done), 32'd1);
            if (n == p1 || n == p2) start = 1'b1;
        end
    endtask

    task automatic check_results(input logic [7:0] cap, input logic [3:0] err, input logic p);
        check("captured", 32'(captured), 32'(cap));
        check("err_count", 32'(err_count), 32'(err));
        check("pass", 32'(pass), 32'(p));
        check("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        #12;
        check("rst_vec", 32'(vec), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_cap", 32'(captured), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // correct function, full sweep
        run_start();
        sweep(24, 0, 0, 1'b1);
        check_results(8'h15, 4'd0, 1'b1);
        check("vec_hold", 32'(vec), 32'd7);

        // restart from DONE with a stuck-at-one DUT
        mode = 1;
        run_start();
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
        sweep(6, 0, 0, 1'b0);
        check_results(8'h03, 4'd1, 1'b0);
        check("fail_idx_s1", 32'(fail_idx), 32'd1);
        check("vec_fail_s1", 32'(vec), 32'd1);
`else
        sweep(24, 0, 0, 1'b0);
        check_results(8'hFF, 4'd5, 1'b0);
`endif

        // inverted DUT
        mode = 2;
        run_start();
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
        sweep(3, 0, 0, 1'b0);
        check_results(8'h00, 4'd1, 1'b0);
        check("fail_idx_inv", 32'(fail_idx), 32'd0);
        check("vec_fail_inv", 32'(vec), 32'd0);
`else
        sweep(24, 0, 0, 1'b0);
        check_results(8'hEA, 4'd8, 1'b0);
`endif

        // start re-pulsed mid-sweep must be ignored
        mode = 0;
        run_start();
        sweep(24, 4, 9, 1'b1);
        check_results(8'h15, 4'd0, 1'b1);
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
        check("fail_idx_pass", 32'(fail_idx), 32'd0);
`endif

        // asynchronous reset mid-sweep while vec=3
        run_start();
        for (int n = 1; n <= 10; n++) @(posedge clk);
        #1 check("pre_rst_vec", 32'(vec), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec", 32'(vec), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(err_count), 32'd0);
        check("arst_cap", 32'(captured), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_start();
        sweep(24, 0, 0, 1'b1);
        check_results(8'h15, 4'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
